// File: rtl/uart_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_loader_pkg
// Purpose  : Shared definitions for the UART program loader. Holds the
//            frame-parser state encoding, the default frame start marker and
//            a helper that sizes the length/count registers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_mem_loader_pkg;

  // Frame-parser states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // The length field on the wire is 16 bits. The register also has to hold
  // DEPTH itself, which needs ADDR_W+1 bits once that exceeds 16.
  function automatic int len_width(input int addr_w);
    return (addr_w + 1 > 16) ? addr_w + 1 : 16;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_mem_loader_rx_event_sync.sv
`default_nettype none
// ============================================================================
// Module   : rx_event_sync
// Purpose  : Brings the receiver's asynchronous dataReady level into the clock
//            domain and turns each high period into a one-clock pulse.
// Ports    : clock     in  system clock
//            reset_n   in  asynchronous active-low reset
//            async_in  in  level from the other clock domain
//            pulse_out out one-clock pulse on each synchronised rising edge
// Revision : 1.0 - initial release
// ============================================================================
module rx_event_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic pulse_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Edge detect on the synchronised level: a long high period yields one pulse.
  assign pulse_out = sync_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_mem_loader
// Purpose  : Parses framed program images arriving byte-by-byte from a UART
//            receiver (SYNC, LEN_LO, LEN_HI, payload, XOR checksum) and writes
//            the payload into memory through a byte-wide write port.
// Ports    : clock      in   system clock
//            reset_n    in   asynchronous active-low reset
//            rx_byte    in   received character, stable while rx_ready high
//            rx_ready   in   receiver dataReady level (asynchronous)
//            mem_we     out  one-clock memory write strobe
//            mem_addr   out  write address
//            mem_wdata  out  write data
//            busy       out  frame in progress
//            load_done  out  sticky: last frame loaded with good checksum
//            load_err   out  sticky: last frame failed
// Revision : 1.0 - initial release
// ============================================================================
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter int         TIMEOUT   = 1000000,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int LEN_W = len_width(ADDR_W);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [LEN_W-1:0] DEPTH    = LEN_W'(1) << ADDR_W;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic byte_evt;

  rx_event_sync u_rx_event_sync (
    .clock     (clock),
    .reset_n   (reset_n),
    .async_in  (rx_ready),
    .pulse_out (byte_evt)
  );

  state_e              state_q,     state_d;
  logic [LEN_W-1:0]    len_q,       len_d;
  logic [LEN_W-1:0]    cnt_q,       cnt_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [7:0]          csum_q,      csum_d;
  logic [TMO_W-1:0]    tmo_q,       tmo_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                err_q,       err_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;

  logic [LEN_W-1:0]    len_full;
  logic [LEN_W-1:0]    cnt_next;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    csum_d      = csum_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    len_full = LEN_W'({rx_byte, len_q[7:0]});
    cnt_next = cnt_q + LEN_W'(1);

    // Inter-byte watchdog: idles at zero outside a frame, restarts on every byte.
    if (state_q == ST_IDLE || byte_evt) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (byte_evt && rx_byte == SYNC_BYTE) begin
          state_d = ST_LEN_LO;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          len_d   = '0;
          cnt_d   = '0;
          addr_d  = '0;
          csum_d  = '0;
        end
      end

      ST_LEN_LO: begin
        if (byte_evt) begin
          len_d   = LEN_W'(rx_byte);
          state_d = ST_LEN_HI;
        end
      end

      ST_LEN_HI: begin
        if (byte_evt) begin
          len_d = len_full;
          if (len_full > DEPTH) begin
            state_d = ST_ERR;
          end else if (len_full == '0) begin
            // Empty image: the checksum byte must be the XOR of nothing (0).
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA;
            addr_d  = '0;
            cnt_d   = '0;
            csum_d  = '0;
          end
        end
      end

      ST_DATA: begin
        if (byte_evt) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = rx_byte;
          csum_d      = csum_q ^ rx_byte;
          // After the final byte of a DEPTH-long image this wraps to 0, but
          // the address is never used again before the next frame resets it.
          addr_d      = addr_q + ADDR_W'(1);
          cnt_d       = cnt_next;
          if (cnt_next == len_q) begin
            state_d = ST_CSUM;
          end
        end
      end

      ST_CSUM: begin
        if (byte_evt) begin
          if (rx_byte == csum_q) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
          end
        end
      end

      ST_ERR: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Timeout abort. A byte arriving on the same clock takes precedence,
    // which the !byte_evt term guarantees.
    if (state_q != ST_IDLE && state_q != ST_ERR && !byte_evt && tmo_q == TMO_LAST) begin
      state_d = ST_ERR;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_mem_loader
// Purpose  : Directed self-checking bench for uart_mem_loader (ADDR_W=8,
//            TIMEOUT=50). A monitor mirrors every write into a byte array.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_mem_loader;

  logic       clock;
  logic       reset_n;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       load_done;
  logic       load_err;

  uart_mem_loader #(
    .ADDR_W    (8),
    .TIMEOUT   (50),
    .SYNC_BYTE (8'hA5)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rx_byte   (rx_byte),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: memory image, write count, last address, strobe width
  // and the done/err exclusivity.
  logic [7:0] mem_img [256];
  int         wr_cnt   = 0;
  int         wr_last  = 0;
  int         we_run   = 0;
  int         we_max   = 0;
  int         both_hi  = 0;

  always @(negedge clock) begin
    if (reset_n && mem_we) begin
      mem_img[mem_addr] = mem_wdata;
      wr_last = int'(mem_addr);
      wr_cnt++;
      we_run++;
      if (we_run > we_max) we_max = we_run;
    end else begin
      we_run = 0;
    end
    if (load_done && load_err) both_hi++;
  end

  task automatic send_byte(input logic [7:0] b, input int hold = 4);
    rx_byte  = b;
    rx_ready = 1'b1;
    repeat (hold) @(posedge clock);
    #1;
    rx_ready = 1'b0;
    repeat (4) @(posedge clock);
    #1;
  endtask

  int base;

  initial begin
    rx_byte  = 8'h00;
    rx_ready = 1'b0;
    reset_n  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy",  32'(busy),      0);
    check("rst_done",  32'(load_done), 0);
    check("rst_err",   32'(load_err),  0);
    check("rst_we",    32'(mem_we),    0);
    check("rst_addr",  32'(mem_addr),  0);
    check("rst_wdata", 32'(mem_wdata), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // 1: good 3-byte frame
    base = wr_cnt;
    send_byte(8'hA5);
    check("t1_busy_after_sync", 32'(busy), 1);
    send_byte(8'h03); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check("t1_busy_before_csum", 32'(busy), 1);
    send_byte(8'h00);
    check("t1_writes", 32'(wr_cnt - base), 3);
    check("t1_mem0", 32'(mem_img[0]), 32'h11);
    check("t1_mem1", 32'(mem_img[1]), 32'h22);
    check("t1_mem2", 32'(mem_img[2]), 32'h33);
    check("t1_done", 32'(load_done), 1);
    check("t1_err",  32'(load_err),  0);
    check("t1_busy", 32'(busy),      0);

    // 2: bad checksum (expected 0x30, sent 0x31)
    base = wr_cnt;
    send_byte(8'hA5);
    check("t2_done_cleared", 32'(load_done), 0);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
    check("t2_writes", 32'(wr_cnt - base), 2);
    check("t2_mem0", 32'(mem_img[0]), 32'h10);
    check("t2_mem1", 32'(mem_img[1]), 32'h20);
    check("t2_err",  32'(load_err),  1);
    check("t2_done", 32'(load_done), 0);
    check("t2_busy", 32'(busy),      0);

    // 3a: len == DEPTH (256), payload 0..255, XOR of 0..255 is 0
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    send_byte(8'h00);
    check("t3_writes",   32'(wr_cnt - base), 256);
    check("t3_mem0",     32'(mem_img[0]),   32'h00);
    check("t3_mem128",   32'(mem_img[128]), 32'h80);
    check("t3_mem255",   32'(mem_img[255]), 32'hFF);
    check("t3_last_addr", 32'(wr_last), 255);
    check("t3_done", 32'(load_done), 1);
    check("t3_err",  32'(load_err),  0);

    // 3b: len == 257 rejected right after LEN_HI
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    check("t3b_err",    32'(load_err),  1);
    check("t3b_done",   32'(load_done), 0);
    check("t3b_busy",   32'(busy),      0);
    check("t3b_writes", 32'(wr_cnt - base), 0);

    // 4: timeout after one of five payload bytes
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00); send_byte(8'hAA);
    check("t4_busy_waiting", 32'(busy),     1);
    check("t4_no_err_yet",   32'(load_err), 0);
    repeat (70) @(posedge clock);
    #1;
    check("t4_err",    32'(load_err), 1);
    check("t4_busy",   32'(busy),     0);
    check("t4_writes", 32'(wr_cnt - base), 1);
    check("t4_mem0",   32'(mem_img[0]), 32'hAA);

    // 5: strays in IDLE ignored, long SYNC gives a single event
    base = wr_cnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    check("t5_stray_busy", 32'(busy),     0);
    check("t5_stray_err",  32'(load_err), 1);
    send_byte(8'hA5, 20);
    check("t5_sync_busy",  32'(busy),     1);
    check("t5_sync_err",   32'(load_err), 0);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h5A); send_byte(8'h5A);
    check("t5_writes", 32'(wr_cnt - base), 1);
    check("t5_mem0",   32'(mem_img[0]), 32'h5A);
    check("t5_done",   32'(load_done), 1);
    check("t5_err",    32'(load_err),  0);

    // 6: asynchronous reset in the middle of DATA
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy),      0);
    check("t6_rst_done", 32'(load_done), 0);
    check("t6_rst_err",  32'(load_err),  0);
    check("t6_rst_we",   32'(mem_we),    0);
    check("t6_rst_addr", 32'(mem_addr),  0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    base = wr_cnt;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h7E); send_byte(8'h7E);
    check("t6_writes",    32'(wr_cnt - base), 1);
    check("t6_mem0",      32'(mem_img[0]), 32'h7E);
    check("t6_last_addr", 32'(wr_last), 0);
    check("t6_done",      32'(load_done), 1);
    check("t6_busy",      32'(busy),      0);

    // Whole-run properties
    check("we_pulse_width", 32'(we_max), 1);
    check("done_err_excl",  32'(both_hi), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
